// File: rtl/fp_normalizer_pipe.sv
// fp_normalizer_pipe: 3-stage normalise / shift / round pipeline producing a packed IEEE-754 result.
// Define FP_NORM_ROUND_MODES_EN to add in_rm (RNE/RTZ/RDN/RUP/RMM); the default build is RNE only.
module fp_normalizer_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IN_W  = 2*MAN_W+3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [IN_W-1:0]      in_man,
  input  logic [EXP_W:0]       in_exp,
`ifdef FP_NORM_ROUND_MODES_EN
  input  logic [2:0]           in_rm,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_inexact
);
  localparam int LO_W  = IN_W - 2;
  localparam int LZC_W = $clog2(LO_W);
  localparam int LZC_N = 1 << LZC_W;
  localparam int SH_W  = LZC_W + 1;
  localparam int XW    = EXP_W + 2;
  localparam int G_BIT = LO_W - 1 - MAN_W;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  // Log-tree leading-zero count; node i at level l+1 merges nodes 2i (upper) and 2i+1 (lower).
  function automatic logic [SH_W-1:0] lzc(input logic [LZC_N-1:0] v);
    logic            vld [LZC_N];
    logic [SH_W-1:0] cnt [LZC_N];
    for (int i = 0; i < LZC_N; i++) begin
      vld[i] = v[LZC_N-1-i];
      cnt[i] = '0;
    end
    for (int l = 0; l < LZC_W; l++) begin
      for (int i = 0; i < (LZC_N >> (l + 1)); i++) begin
        cnt[i] = vld[2*i] ? cnt[2*i] : SH_W'(1 << l) + cnt[2*i+1];
        vld[i] = vld[2*i] | vld[2*i+1];
      end
    end
    return cnt[0];
  endfunction

  logic                 s1_valid, s1_sign, s1_sticky, s1_zero, s1_neg;
  logic [IN_W-1:0]      s1_man;
  logic [XW-1:0]        s1_exp;
  logic [SH_W-1:0]      s1_shift;
  logic                 s2_valid, s2_sign, s2_sticky, s2_zero, s2_flush;
  logic [LO_W-1:0]      s2_man;
  logic [XW-1:0]        s2_exp;
`ifdef FP_NORM_ROUND_MODES_EN
  logic [2:0]           s1_rm, s2_rm;
`endif

  logic s1_adv, s2_adv, s3_adv;
  assign s3_adv   = !out_valid | out_ready;
  assign s2_adv   = !s2_valid | s3_adv;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  logic [LZC_N-1:0] lzc_in;
  logic [IN_W-1:0]  s1_man_d;
  logic [XW-1:0]    s1_exp_d;
  logic [SH_W-1:0]  s1_shift_d;
  logic             s1_sticky_d, s1_zero_d;

  always_comb begin
    // Pad below the fraction with ones so the count saturates inside the real bits.
    lzc_in                   = '1;
    lzc_in[LZC_N-1 -: LO_W]  = in_man[LO_W-1:0];
    s1_man_d    = in_man;
    s1_exp_d    = XW'(in_exp[EXP_W-1:0]);
    s1_shift_d  = '0;
    s1_sticky_d = 1'b0;
    s1_zero_d   = 1'b0;
    if (in_man[IN_W-1]) begin
      s1_man_d    = in_man >> 1;
      s1_exp_d    = s1_exp_d + XW'(1);
      s1_sticky_d = in_man[0];
    end else if (!in_man[IN_W-2]) begin
      if (in_man == '0) begin
        s1_zero_d = 1'b1;
        s1_exp_d  = '0;
      end else begin
        s1_shift_d = lzc(lzc_in) + SH_W'(1);
      end
    end
  end

  logic [LO_W-1:0] s2_man_d;
  logic [XW-1:0]   s2_exp_d;
  logic            s2_flush_d;

  always_comb begin
    s2_man_d   = LO_W'(s1_man << s1_shift);
    s2_exp_d   = s1_exp - XW'(s1_shift);
    s2_flush_d = !s1_zero && (s1_neg || s2_exp_d[XW-1] || (s2_exp_d == '0));
    if (s1_zero) s2_exp_d = '0;
  end

  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       frac_r;
  logic [XW-1:0]        exp_f;
  logic                 g_bit, s_bit, inc, ovf_to_max;
  logic [EXP_W+MAN_W:0] res_d;
  logic                 ovf_d, unf_d, inx_d;

  always_comb begin
    frac       = s2_man[LO_W-1 -: MAN_W];
    g_bit      = s2_man[G_BIT];
    s_bit      = (|s2_man[G_BIT-1:0]) | s2_sticky;
    inc        = g_bit & (s_bit | frac[0]);
    ovf_to_max = 1'b0;
`ifdef FP_NORM_ROUND_MODES_EN
    case (s2_rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = (g_bit | s_bit) & s2_sign;
      3'b011:  inc = (g_bit | s_bit) & !s2_sign;
      3'b100:  inc = g_bit;
      default: inc = g_bit & (s_bit | frac[0]);
    endcase
    ovf_to_max = (s2_rm == 3'b001) || ((s2_rm == 3'b010) && !s2_sign) ||
                 ((s2_rm == 3'b011) && s2_sign);
`endif
    frac_r = {1'b0, frac} + (MAN_W+1)'(inc);
    exp_f  = s2_exp + XW'(frac_r[MAN_W]);
    res_d  = {s2_sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = g_bit | s_bit;
    if (s2_zero) begin
      res_d = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      inx_d = 1'b0;
    end else if (s2_flush) begin
      res_d = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (!exp_f[XW-1] && (exp_f >= EXP_MAX)) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      if (ovf_to_max) res_d = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else            res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_man        <= '0;
      s1_exp        <= '0;
      s1_shift      <= '0;
      s1_sticky     <= 1'b0;
      s1_zero       <= 1'b0;
      s1_neg        <= 1'b0;
      s2_valid      <= 1'b0;
      s2_sign       <= 1'b0;
      s2_man        <= '0;
      s2_exp        <= '0;
      s2_sticky     <= 1'b0;
      s2_zero       <= 1'b0;
      s2_flush      <= 1'b0;
`ifdef FP_NORM_ROUND_MODES_EN
      s1_rm         <= '0;
      s2_rm         <= '0;
`endif
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (s3_adv) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_result    <= res_d;
          out_overflow  <= ovf_d;
          out_underflow <= unf_d;
          out_inexact   <= inx_d;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sign   <= s1_sign;
          s2_man    <= s2_man_d;
          s2_exp    <= s2_exp_d;
          s2_sticky <= s1_sticky;
          s2_zero   <= s1_zero;
          s2_flush  <= s2_flush_d;
`ifdef FP_NORM_ROUND_MODES_EN
          s2_rm     <= s1_rm;
`endif
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign   <= in_sign;
          s1_man    <= s1_man_d;
          s1_exp    <= s1_exp_d;
          s1_shift  <= s1_shift_d;
          s1_sticky <= s1_sticky_d;
          s1_zero   <= s1_zero_d;
          s1_neg    <= in_exp[EXP_W];
`ifdef FP_NORM_ROUND_MODES_EN
          s1_rm     <= in_rm;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// tb_fp_normalizer_pipe: directed vectors with hand-computed IEEE-754 results, latency,
// backpressure and mid-stream reset checks for fp_normalizer_pipe (default EXP_W=8, MAN_W=23).
module tb_fp_normalizer_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int IN_W  = 2*MAN_W+3;
  localparam int NV    = 15;
  localparam logic [IN_W-1:0] ONE = IN_W'(1) << (IN_W-2);

  typedef struct {
    logic            sign;
    logic [IN_W-1:0] man;
    logic [EXP_W:0]  exp;
    logic [31:0]     res;
    logic [2:0]      flg;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_sign = 1'b0;
  logic [IN_W-1:0]      in_man = '0;
  logic [EXP_W:0]       in_exp = '0;
`ifdef FP_NORM_ROUND_MODES_EN
  logic [2:0]           in_rm = 3'b000;
`endif
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [EXP_W+MAN_W:0] out_result;
  logic                 out_overflow, out_underflow, out_inexact;

  fp_normalizer_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IN_W(IN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_man        (in_man),
    .in_exp        (in_exp),
`ifdef FP_NORM_ROUND_MODES_EN
    .in_rm         (in_rm),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          stray_cnt = 0;
  int          n_out = 0;
  logic [34:0] exp_q [$];
  vec_t        tbl [NV];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic put(input int k);
    in_valid = 1'b1;
    in_sign  = tbl[k].sign;
    in_man   = tbl[k].man;
    in_exp   = tbl[k].exp;
  endtask

  task automatic push(input int k);
    exp_q.push_back({tbl[k].res, tbl[k].flg});
  endtask

  // Called at posedge+1; offers beats first..first+n-1 and records each one as it is accepted.
  task automatic drive_beats(input int first, input int n);
    int idx = first;
    int guard = 0;
    while (idx < first + n && guard < 200) begin
      put(idx);
      @(negedge clk);
      if (in_ready) begin
        push(idx);
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (idx != first + n) chk("drive_timeout", 64'(idx), 64'(first + n));
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        stray_cnt++;
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        chk("result", 64'(out_result), 64'(e[34:3]));
        chk("flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(e[2:0]));
        n_out++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int n_before;

    tbl[0]  = '{1'b0, ONE, 9'd127, 32'h3F80_0000, 3'b000};
    tbl[1]  = '{1'b0, IN_W'(1) << 40, 9'd127, 32'h3C00_0000, 3'b000};
    tbl[2]  = '{1'b0, ONE | (IN_W'(23'h7F_FFFF) << 24) | (IN_W'(1) << 23), 9'd127, 32'h4000_0000, 3'b001};
    tbl[3]  = '{1'b0, IN_W'(1) << 48, 9'd254, 32'h7F80_0000, 3'b101};
    tbl[4]  = '{1'b1, IN_W'(1) << 48, 9'd254, 32'hFF80_0000, 3'b101};
    tbl[5]  = '{1'b0, IN_W'(1) << 40, 9'd5, 32'h0000_0000, 3'b011};
    tbl[6]  = '{1'b0, '0, 9'd90, 32'h0000_0000, 3'b000};
    tbl[7]  = '{1'b0, ONE | (IN_W'(1) << 23), 9'd127, 32'h3F80_0000, 3'b001};
    tbl[8]  = '{1'b0, (IN_W'(1) << 48) | (IN_W'(1) << 24) | IN_W'(1), 9'd127, 32'h4000_0001, 3'b001};
    tbl[9]  = '{1'b0, ONE, 9'd254, 32'h7F00_0000, 3'b000};
    tbl[10] = '{1'b0, ONE, 9'd1, 32'h0080_0000, 3'b000};
    tbl[11] = '{1'b0, ONE, 9'd0, 32'h0000_0000, 3'b011};
    tbl[12] = '{1'b1, ONE, 9'h164, 32'h8000_0000, 3'b011};
    tbl[13] = '{1'b1, ONE | (IN_W'(1) << 24) | (IN_W'(1) << 23), 9'd127, 32'hBF80_0002, 3'b001};
    tbl[14] = '{1'b0, IN_W'(1), 9'd127, 32'h2800_0000, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single beat: result must appear on the third edge counting the accepting one.
    put(0);
    @(negedge clk);
    chk("lat_accept", 64'(in_ready), 64'd1);
    push(0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_c1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_c2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_c3", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("lat_once", 64'(out_valid), 64'd0);
    drain();

    // Back-to-back stream of every directed vector.
    n_before = n_out;
    drive_beats(0, NV);
    drain();
    chk("stream_count", 64'(n_out - n_before), 64'(NV));

    // Backpressure: only three beats fit while the consumer stalls.
    out_ready = 1'b0;
    n_before  = n_out;
    acc       = 0;
    for (int c = 0; c < 5; c++) begin
      put(1 + acc);
      @(negedge clk);
      if (in_ready) begin
        push(1 + acc);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_result", 64'(out_result), 64'(tbl[1].res));
    chk("bp_hold_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(tbl[1].flg));
    out_ready = 1'b1;
    drive_beats(1 + acc, 5 - acc);
    drain();
    chk("bp_delivered", 64'(n_out - n_before), 64'd5);

    // Reset in the middle of a stream drops everything in flight.
    drive_beats(1, 5);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(out_result), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    n_before = n_out;
    drive_beats(13, 2);
    drain();
    chk("post_rst_count", 64'(n_out - n_before), 64'd2);
    chk("no_stale", 64'(stray_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
